// File: rtl/fifo_rd_burst.sv
// Burst read controller for a show-ahead FIFO with a 2-entry skid buffer.
// Optional stats counters enabled by FIFO_RD_BURST_STATS_EN.
module fifo_rd_burst #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = $clog2(DEPTH+1),
  parameter int THRESHOLD = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_flush,
  input  logic                 i_fifo_empty,
  input  logic [CNT_WIDTH-1:0] i_fifo_count,
  input  logic [WIDTH-1:0]     i_fifo_data,
  output logic                 o_fifo_pop,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_last,
  input  logic                 i_ready,
  output logic                 o_busy
`ifdef FIFO_RD_BURST_STATS_EN
  ,
  output logic [15:0]          o_burst_cnt,
  output logic [31:0]          o_word_cnt
`endif
);

  localparam int RW  = $clog2(MAX_BURST+1);
  localparam int CW  = (CNT_WIDTH > RW) ? CNT_WIDTH : RW;
  localparam int THR = (THRESHOLD > DEPTH) ? DEPTH : THRESHOLD;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  state_t          state;
  logic [RW-1:0]   remaining;
  logic            flush_pend;
  logic [1:0]      occ;
  logic [WIDTH-1:0] tl_data;
  logic            tl_last;

  logic            pop;
  logic            xfer;
  logic            new_last;
  logic            start;
  logic [CW-1:0]   cnt_ext;
  logic [RW-1:0]   burst_len;

  assign pop = (state == BURST) & ~i_fifo_empty &
               (remaining != '0) & (occ < 2'd2);
  assign o_fifo_pop = pop;
  assign xfer = o_valid & i_ready;
  assign new_last = (remaining == RW'(1));

  assign start = i_enable &
    ((i_fifo_count >= CNT_WIDTH'(THR)) |
     (flush_pend & ~i_fifo_empty));

  assign cnt_ext = CW'(i_fifo_count);
  assign burst_len = (cnt_ext < CW'(MAX_BURST)) ?
                     RW'(cnt_ext) : RW'(MAX_BURST);

  // Output register is the skid head; tl_* holds the second entry.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      occ     <= 2'd0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      tl_data <= '0;
      tl_last <= 1'b0;
    end else begin
      unique case ({pop, xfer})
        2'b10: begin
          if (occ == 2'd0) begin
            o_data <= i_fifo_data;
            o_last <= new_last;
          end else begin
            tl_data <= i_fifo_data;
            tl_last <= new_last;
          end
          occ     <= occ + 2'd1;
          o_valid <= 1'b1;
        end
        2'b01: begin
          o_data  <= tl_data;
          o_last  <= tl_last;
          occ     <= occ - 2'd1;
          o_valid <= (occ == 2'd2);
        end
        2'b11: begin
          o_data <= i_fifo_data;
          o_last <= new_last;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      remaining  <= '0;
      flush_pend <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= BURST;
            remaining  <= burst_len;
            flush_pend <= 1'b0;
            o_busy     <= 1'b1;
          end else if (i_fifo_empty) begin
            flush_pend <= 1'b0;
          end
        end
        BURST: begin
          if (remaining == '0) begin
            state <= DRAIN;
          end else if (pop) begin
            remaining <= remaining - RW'(1);
            if (remaining == RW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((occ == 2'd0) && !o_valid) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
      // A flush seen during a burst is kept for the next one.
      if (i_flush) flush_pend <= 1'b1;
    end
  end

`ifdef FIFO_RD_BURST_STATS_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_burst_cnt <= '0;
      o_word_cnt  <= '0;
    end else if (xfer) begin
      o_word_cnt <= o_word_cnt + 32'd1;
      if (o_last) o_burst_cnt <= o_burst_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_burst.sv
// Directed bench for fifo_rd_burst with a show-ahead FIFO model.
// Stats counters are checked when FIFO_RD_BURST_STATS_EN is defined.
module tb_fifo_rd_burst;

  localparam int W = 32;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_fifo_empty = 1'b1;
  logic [4:0]    i_fifo_count = '0;
  logic [W-1:0]  i_fifo_data = '0;
  logic          o_fifo_pop;
  logic          o_valid;
  logic [W-1:0]  o_data;
  logic          o_last;
  logic          i_ready = 1'b1;
  logic          o_busy;
`ifdef FIFO_RD_BURST_STATS_EN
  logic [15:0]   o_burst_cnt;
  logic [31:0]   o_word_cnt;
`endif

  fifo_rd_burst dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_flush      (i_flush),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_count (i_fifo_count),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_pop   (o_fifo_pop),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_last       (o_last),
    .i_ready      (i_ready),
    .o_busy       (o_busy)
`ifdef FIFO_RD_BURST_STATS_EN
    ,
    .o_burst_cnt  (o_burst_cnt),
    .o_word_cnt   (o_word_cnt)
`endif
  );

  always #5 i_clock = ~i_clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] exq[$];
  int n_xfer, n_pop, cyc, last_xfer_cyc, first_pop_cyc, last_pop_cyc;
  logic [31:0] lastmask;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    i_fifo_empty = (fq.size() == 0);
    i_fifo_count = 5'(fq.size());
    if (fq.size() != 0) i_fifo_data = fq[0];
    else i_fifo_data = '0;
  endtask

  task automatic push(logic [W-1:0] v);
    fq.push_back(v);
    exq.push_back(v);
    drive_fifo();
  endtask

  task automatic clear_log();
    n_xfer = 0;
    n_pop = 0;
    lastmask = '0;
    first_pop_cyc = -1;
    last_pop_cyc = -1;
  endtask

  task automatic tick();
    logic p, x, l;
    logic [W-1:0] d, e;
    p = o_fifo_pop;
    x = o_valid & i_ready;
    d = o_data;
    l = o_last;
    check("pop_while_empty", p & i_fifo_empty, 0);
    check("skid_overflow", dut.occ > 2'd2, 0);
    if (x) begin
      if (exq.size() == 0) begin
        check("extra_word", 1, 0);
      end else begin
        e = exq.pop_front();
        check("word_order", d, e);
      end
      if (n_xfer < 32) lastmask[n_xfer] = l;
      n_xfer++;
      last_xfer_cyc = cyc;
    end
    if (p) begin
      n_pop++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    @(posedge i_clock);
    #1;
    cyc++;
    if (p && fq.size() != 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic run_burst(string tag);
    int k;
    logic saw;
    k = 0;
    while (!o_busy && k < 40) begin
      tick();
      k++;
    end
    saw = o_busy;
    while (o_busy && k < 80) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, saw && !o_busy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc = 0;
    last_xfer_cyc = 0;
    clear_log();
    repeat (2) @(posedge i_clock);
    #1;
    check("rst_pop", o_fifo_pop, 0);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_last", o_last, 0);
    check("rst_busy", o_busy, 0);
    i_reset = 1'b0;
    tick();

    // Threshold burst of 4
    i_enable = 1'b1;
    i_ready = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("t1_idle_below_thr", o_busy, 0);
      push(32'h100 + 32'(i));
      if (i < 3) tick();
    end
    run_burst("t1");
    check("t1_pops", n_pop, 4);
    check("t1_pop_span", last_pop_cyc - first_pop_cyc, 3);
    check("t1_words", n_xfer, 4);
    check("t1_last", lastmask, 32'h8);
    check("t1_idle_lat", cyc - last_xfer_cyc, 2);
    check("t1_left", exq.size(), 0);

    // Count 12 splits into bursts of 8 and 4
    i_enable = 1'b0;
    for (int i = 0; i < 12; i++) push(32'h200 + 32'(i));
    tick();
    i_enable = 1'b1;
    clear_log();
    run_burst("t2a");
    check("t2a_words", n_xfer, 8);
    check("t2a_last", lastmask, 32'h80);
    clear_log();
    run_burst("t2b");
    check("t2b_words", n_xfer, 4);
    check("t2b_last", lastmask, 32'h8);
    check("t2_fifo_empty", fq.size(), 0);

    // Flush drains a short FIFO
    push(32'h300);
    push(32'h301);
    repeat (3) tick();
    check("t3_no_burst", o_busy, 0);
    clear_log();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    run_burst("t3");
    check("t3_words", n_xfer, 2);
    check("t3_last", lastmask, 32'h2);

    // Flush on an empty FIFO is dropped
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    repeat (2) tick();
    push(32'h3a0);
    clear_log();
    repeat (4) tick();
    check("t3_empty_flush_busy", o_busy, 0);
    check("t3_empty_flush_pop", n_pop, 0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    run_burst("t3c");
    check("t3c_words", n_xfer, 1);
    check("t3c_last", lastmask, 32'h1);

    // Backpressure mid-burst
    i_enable = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h400 + 32'(i));
    tick();
    clear_log();
    i_enable = 1'b1;
    repeat (4) tick();
    i_ready = 1'b0;
    n_pop = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_pop_held", o_fifo_pop, 0);
      check("t4_valid_held", o_valid, 1);
      check("t4_data_held", o_data, 32'h402);
    end
    check("t4_pops_in_stall", n_pop, 1);
    i_ready = 1'b1;
    run_burst("t4");
    check("t4_words", n_xfer, 8);
    check("t4_last", lastmask, 32'h80);
    check("t4_left", exq.size(), 0);

    // Async reset with two words in the skid
    i_enable = 1'b0;
    i_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h500 + 32'(i));
    tick();
    i_enable = 1'b1;
    repeat (3) tick();
    check("t5_pre_valid", o_valid, 1);
    check("t5_pre_data", o_data, 32'h500);
    i_enable = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    check("t5_rst_pop", o_fifo_pop, 0);
    check("t5_rst_valid", o_valid, 0);
    check("t5_rst_data", o_data, 0);
    check("t5_rst_last", o_last, 0);
    check("t5_rst_busy", o_busy, 0);
    void'(exq.pop_front());
    void'(exq.pop_front());
    tick();
    i_reset = 1'b0;
    i_ready = 1'b1;
    clear_log();
    repeat (3) tick();
    check("t5_hold_off", o_busy, 0);
    check("t5_fifo_kept", fq.size(), 6);
    i_enable = 1'b1;
    run_burst("t5");
    check("t5_words", n_xfer, 6);
    check("t5_last", lastmask, 32'h20);

    // Three bursts of four for the statistics counters
    #2;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    clear_log();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) push(32'h600 + 32'(b * 4 + i));
      run_burst("t6");
    end
    check("t6_words", n_xfer, 12);
    check("t6_last", lastmask, 32'h888);
`ifdef FIFO_RD_BURST_STATS_EN
    check("t6_burst_cnt", o_burst_cnt, 3);
    check("t6_word_cnt", o_word_cnt, 12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
